// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle MIPS core.
// Gates commit (cpu_en) and selects the reset vector while idle.
module cpu_run_ctrl #(
    parameter int               CNT_W      = 32,
    parameter logic [31:0]      HALT_INST  = 32'h0000000C,
    parameter logic [CNT_W-1:0] MAX_CYCLES = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             clear,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      cur_pc,
    input  logic [31:0]      inst,
    output logic             init_pc,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_STEP  = 3'd4;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_HALT = 2'b01;
    localparam logic [1:0] C_BP   = 2'b10;
    localparam logic [1:0] C_WD   = 2'b11;

    logic [2:0] cur_st;
    logic [2:0] nxt_st;
    logic [1:0] cause_d;
    logic       bp_skip;
    logic       skip_d;
    logic       in_exec;
    logic       halt_hit;
    logic       bp_hit;
    logic       wd_hit;

    assign in_exec  = (cur_st == S_RUN) || (cur_st == S_STEP);
    assign halt_hit = (inst == HALT_INST);
    assign bp_hit   = bp_en && (cur_pc == bp_addr) && !bp_skip;
    assign wd_hit   = (MAX_CYCLES != '0) && (cycle_count == MAX_CYCLES);

    // Any abort condition this cycle suppresses the commit.
    assign cpu_en = in_exec && !clear && !stop
                    && !halt_hit && !bp_hit && !wd_hit;

    assign init_pc = (cur_st == S_IDLE);

    always_comb begin
        state = cur_st[1:0];
        if (cur_st == S_STEP) begin
            state = 2'b01;
        end
    end

    always_comb begin
        nxt_st  = cur_st;
        cause_d = halt_cause;
        skip_d  = bp_skip;
        if (clear) begin
            nxt_st  = S_IDLE;
            cause_d = C_NONE;
            skip_d  = 1'b0;
        end else begin
            unique case (cur_st)
                S_IDLE: begin
                    if (start) begin
                        nxt_st  = S_RUN;
                        cause_d = C_NONE;
                    end else if (step) begin
                        nxt_st  = S_STEP;
                        cause_d = C_NONE;
                    end
                end
                S_RUN, S_STEP: begin
                    skip_d = 1'b0;
                    if (stop) begin
                        nxt_st  = S_PAUSE;
                        cause_d = C_NONE;
                    end else if (halt_hit) begin
                        nxt_st  = S_HALT;
                        cause_d = C_HALT;
                    end else if (bp_hit) begin
                        nxt_st  = S_PAUSE;
                        cause_d = C_BP;
                    end else if (wd_hit) begin
                        nxt_st  = S_HALT;
                        cause_d = C_WD;
                    end else if (cur_st == S_STEP) begin
                        nxt_st  = S_PAUSE;
                        cause_d = C_NONE;
                    end
                end
                S_PAUSE: begin
                    // Resuming must step over the breakpoint we stopped on.
                    if (start) begin
                        nxt_st  = S_RUN;
                        cause_d = C_NONE;
                        skip_d  = 1'b1;
                    end else if (step) begin
                        nxt_st  = S_STEP;
                        cause_d = C_NONE;
                        skip_d  = 1'b1;
                    end
                end
                S_HALT: begin
                    nxt_st = S_HALT;
                end
                default: begin
                    nxt_st  = S_IDLE;
                    cause_d = C_NONE;
                    skip_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st     <= S_IDLE;
            halt_cause <= C_NONE;
            bp_skip    <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            halt_cause <= cause_d;
            bp_skip    <= skip_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else if (clear) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (in_exec && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (cpu_en && (retired_count != '1)) begin
                retired_count <= retired_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus a random run
// against a behavioural model of the run/step/halt rules.
module tb_cpu_run_ctrl;

    localparam logic [31:0] HALT = 32'h0000000C;
    localparam logic [31:0] RVEC = 32'h00400020;

    logic        clk;
    logic        rst_n;
    logic        start, step, stop, clear, bp_en;
    logic [31:0] bp_addr, cur_pc, inst;

    logic        init_pc, cpu_en;
    logic [1:0]  state, cause;
    logic [31:0] cyc, ret;

    logic        w_init, w_en;
    logic [1:0]  w_state, w_cause;
    logic [31:0] w_cyc, w_ret;

    logic        s_init, s_en;
    logic [1:0]  s_state, s_cause;
    logic [2:0]  s_cyc, s_ret;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .stop(stop), .clear(clear), .bp_en(bp_en), .bp_addr(bp_addr),
        .cur_pc(cur_pc), .inst(inst), .init_pc(init_pc), .cpu_en(cpu_en),
        .state(state), .halt_cause(cause),
        .cycle_count(cyc), .retired_count(ret)
    );

    cpu_run_ctrl #(.MAX_CYCLES(32'd4)) dut_wd (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .stop(stop), .clear(clear), .bp_en(bp_en), .bp_addr(bp_addr),
        .cur_pc(cur_pc), .inst(inst), .init_pc(w_init), .cpu_en(w_en),
        .state(w_state), .halt_cause(w_cause),
        .cycle_count(w_cyc), .retired_count(w_ret)
    );

    cpu_run_ctrl #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .stop(stop), .clear(clear), .bp_en(bp_en), .bp_addr(bp_addr),
        .cur_pc(cur_pc), .inst(inst), .init_pc(s_init), .cpu_en(s_en),
        .state(s_state), .halt_cause(s_cause),
        .cycle_count(s_cyc), .retired_count(s_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode names, not encodings of the DUT.
    typedef enum {M_IDLE, M_RUN, M_STEP, M_PAUSE, M_HALT} mode_t;
    mode_t       m_mode;
    logic [1:0]  m_cause;
    longint      m_cyc, m_ret;
    bit          m_skip;

    function automatic bit m_commit();
        bit busy;
        busy = (m_mode == M_RUN) || (m_mode == M_STEP);
        if (!busy || clear || stop || inst == HALT) return 0;
        if (bp_en && cur_pc == bp_addr && !m_skip) return 0;
        return 1;
    endfunction

    function automatic logic [1:0] m_state();
        case (m_mode)
            M_IDLE:  return 2'd0;
            M_PAUSE: return 2'd2;
            M_HALT:  return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    task automatic m_reset();
        m_mode = M_IDLE; m_cause = 0; m_cyc = 0; m_ret = 0; m_skip = 0;
    endtask

    task automatic m_clock();
        bit c;
        c = m_commit();
        if (clear) begin
            m_reset();
            return;
        end
        if (m_mode == M_RUN || m_mode == M_STEP) begin
            m_cyc++;
            if (c) m_ret++;
            if (stop) begin m_mode = M_PAUSE; m_cause = 0; end
            else if (inst == HALT) begin m_mode = M_HALT; m_cause = 1; end
            else if (!c) begin m_mode = M_PAUSE; m_cause = 2; end
            else if (m_mode == M_STEP) begin m_mode = M_PAUSE; m_cause = 0; end
            m_skip = 0;
        end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
            if (start || step) begin
                m_skip  = (m_mode == M_PAUSE);
                m_mode  = start ? M_RUN : M_STEP;
                m_cause = 0;
            end
        end
    endtask

    task automatic idle_in();
        start = 0; step = 0; stop = 0; clear = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        bp_en = 0; bp_addr = 0; cur_pc = RVEC; inst = 32'h00000020;
        rst_n = 0;
        tick();
        rst_n = 1;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        if ({state, init_pc, cpu_en, cause} !== 6'b00_1_0_00) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 001000",
                     {state, init_pc, cpu_en, cause});
        end
        n_tests++;
        if (cyc !== 0 || ret !== 0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", cyc, ret);
        end
        n_tests++;
    endtask

    task automatic test_halt_opcode();
        int en_cnt;
        do_reset();
        start = 1;
        #1;
        if (cpu_en !== 0 || init_pc !== 1) begin
            n_fail++;
            $display("FAIL idle_en: got %b%b want 01", cpu_en, init_pc);
        end
        n_tests++;
        tick();
        start = 0;
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cur_pc = RVEC + 32'(4 * i);
            inst = 32'h01000000 | 32'($urandom_range(0, 255) << 4);
            #1;
            if (cpu_en === 1 && init_pc === 0) en_cnt++;
            tick();
        end
        if (en_cnt !== 5) begin
            n_fail++;
            $display("FAIL run_commit: got %0d want 5", en_cnt);
        end
        n_tests++;
        inst = HALT;
        #1;
        if (cpu_en !== 0) begin
            n_fail++;
            $display("FAIL halt_en: got %b want 0", cpu_en);
        end
        n_tests++;
        tick();
        if (state !== 2'd3 || cause !== 2'd1 || ret !== 5 || cyc !== 6) begin
            n_fail++;
            $display("FAIL halt_op: got s%0d c%0d r%0d y%0d want s3 c1 r5 y6",
                     state, cause, ret, cyc);
        end
        n_tests++;
    endtask

    task automatic test_breakpoint();
        logic [4:0] en_seq;
        do_reset();
        bp_en = 1; bp_addr = 32'h00400028;
        start = 1;
        tick();
        start = 0;
        en_seq = 0;
        for (int i = 0; i < 3; i++) begin
            cur_pc = RVEC + 32'(4 * i);
            #1;
            en_seq[i] = cpu_en;
            tick();
        end
        if (en_seq[2:0] !== 3'b011 || state !== 2'd2 || cause !== 2'd2
            || ret !== 2) begin
            n_fail++;
            $display("FAIL bp_stop: got e%b s%0d c%0d r%0d want e011 s2 c2 r2",
                     en_seq[2:0], state, cause, ret);
        end
        n_tests++;
        start = 1;
        #1;
        en_seq[3] = cpu_en;
        tick();
        start = 0;
        #1;
        en_seq[4] = cpu_en;
        if (en_seq[4:3] !== 2'b10 || cause !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_resume: got e%b c%0d want e10 c0",
                     en_seq[4:3], cause);
        end
        n_tests++;
        tick();
        cur_pc = 32'h0040002C;
        tick();
        cur_pc = 32'h00400028;
        #1;
        if (cpu_en !== 0 || state !== 2'd1 || ret !== 4) begin
            n_fail++;
            $display("FAIL bp_rehit: got e%b s%0d r%0d want e0 s1 r4",
                     cpu_en, state, ret);
        end
        n_tests++;
        tick();
        bp_en = 0;
    endtask

    task automatic test_step();
        int good;
        do_reset();
        good = 0;
        for (int i = 0; i < 3; i++) begin
            step = 1;
            #1;
            if (cpu_en === 0) good++;
            tick();
            step = 0;
            cur_pc = RVEC + 32'(4 * i);
            #1;
            if (state === 2'd1 && cpu_en === 1 && init_pc === 0) good++;
            tick();
            if (state === 2'd2 && cause === 2'd0) good++;
        end
        if (good !== 9 || ret !== 3 || cyc !== 3) begin
            n_fail++;
            $display("FAIL step3: got g%0d r%0d y%0d want g9 r3 y3",
                     good, ret, cyc);
        end
        n_tests++;
    endtask

    task automatic test_watchdog();
        logic [4:0] en_seq;
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            cur_pc = RVEC + 32'(4 * i);
            #1;
            en_seq[i] = w_en;
            tick();
        end
        if (en_seq !== 5'b01111) begin
            n_fail++;
            $display("FAIL wd_en: got %b want 01111", en_seq);
        end
        n_tests++;
        if (w_state !== 2'd3 || w_cause !== 2'd3 || w_cyc !== 5 || w_ret !== 4) begin
            n_fail++;
            $display("FAIL wd_halt: got s%0d c%0d y%0d r%0d want s3 c3 y5 r4",
                     w_state, w_cause, w_cyc, w_ret);
        end
        n_tests++;
    endtask

    task automatic test_stop_clear();
        do_reset();
        start = 1;
        tick();
        start = 0;
        tick();
        stop = 1; inst = HALT;
        #1;
        if (cpu_en !== 0) begin
            n_fail++;
            $display("FAIL stop_en: got %b want 0", cpu_en);
        end
        n_tests++;
        tick();
        stop = 0; inst = 32'h00000020;
        if (state !== 2'd2 || cause !== 2'd0 || ret !== 1) begin
            n_fail++;
            $display("FAIL stop_halt: got s%0d c%0d r%0d want s2 c0 r1",
                     state, cause, ret);
        end
        n_tests++;
        start = 1;
        tick();
        start = 0; stop = 1; clear = 1; inst = HALT;
        #1;
        if (cpu_en !== 0) begin
            n_fail++;
            $display("FAIL clear_en: got %b want 0", cpu_en);
        end
        n_tests++;
        tick();
        idle_in(); inst = 32'h00000020;
        if (state !== 0 || init_pc !== 1 || cyc !== 0 || ret !== 0) begin
            n_fail++;
            $display("FAIL clear: got s%0d i%b y%0d r%0d want s0 i1 y0 r0",
                     state, init_pc, cyc, ret);
        end
        n_tests++;
    endtask

    task automatic test_async_reset();
        logic [31:0] y;
        do_reset();
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        if (state !== 0 || init_pc !== 1 || cpu_en !== 0 || cyc !== 0
            || ret !== 0 || cause !== 0) begin
            n_fail++;
            $display("FAIL async_rst: got s%0d i%b e%b y%0d r%0d want s0 i1 e0 y0 r0",
                     state, init_pc, cpu_en, cyc, ret);
        end
        n_tests++;
        #2;
        rst_n = 1;
        tick();
        start = 1;
        tick();
        start = 0; inst = HALT;
        tick();
        y = cyc;
        start = 1; step = 1; stop = 1;
        #1;
        if (cpu_en !== 0) begin
            n_fail++;
            $display("FAIL halt_en2: got %b want 0", cpu_en);
        end
        n_tests++;
        tick();
        idle_in();
        tick();
        if (state !== 2'd3 || cause !== 2'd1 || cyc !== y) begin
            n_fail++;
            $display("FAIL halt_ign: got s%0d c%0d y%0d want s3 c1 y%0d",
                     state, cause, cyc, y);
        end
        n_tests++;
        inst = 32'h00000020;
    endtask

    task automatic test_saturation();
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 10; i++) tick();
        if (s_cyc !== 3'd7 || s_ret !== 3'd7 || ret !== 10) begin
            n_fail++;
            $display("FAIL saturate: got y%0d r%0d R%0d want y7 r7 R10",
                     s_cyc, s_ret, ret);
        end
        n_tests++;
    endtask

    task automatic test_random();
        bit exp_en;
        do_reset();
        bp_addr = RVEC + 32'd12;
        for (int n = 0; n < 600; n++) begin
            start  = ($urandom_range(0, 99) < 15);
            step   = ($urandom_range(0, 99) < 15);
            stop   = ($urandom_range(0, 99) < 6);
            clear  = ($urandom_range(0, 99) < 3);
            bp_en  = ($urandom_range(0, 99) < 60);
            cur_pc = RVEC + 32'(4 * $urandom_range(0, 5));
            inst   = ($urandom_range(0, 99) < 4) ? HALT : $urandom | 32'h100;
            #1;
            exp_en = m_commit();
            if (cpu_en !== exp_en || init_pc !== (m_mode == M_IDLE)) begin
                n_fail++;
                $display("FAIL rnd_en[%0d]: got e%b i%b want e%b i%b",
                         n, cpu_en, init_pc, exp_en, m_mode == M_IDLE);
            end
            n_tests++;
            tick();
            m_clock();
            if (state !== m_state() || cause !== m_cause
                || cyc !== 32'(m_cyc) || ret !== 32'(m_ret)) begin
                n_fail++;
                $display("FAIL rnd_reg[%0d]: got s%0d c%0d y%0d r%0d want s%0d c%0d y%0d r%0d",
                         n, state, cause, cyc, ret,
                         m_state(), m_cause, m_cyc, m_ret);
            end
            n_tests++;
            // Keep the random run from parking in HALT for long.
            if (m_mode == M_HALT && $urandom_range(0, 3) == 0) begin
                idle_in();
                clear = 1;
                #1;
                tick();
                m_clock();
            end
        end
        idle_in();
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        bp_en = 0; bp_addr = 0; cur_pc = RVEC; inst = 0;
        test_reset();
        test_halt_opcode();
        test_breakpoint();
        test_step();
        test_watchdog();
        test_stop_clear();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
